// File: rtl/prog_data_mem.sv
// Single-clock memory with a registered data port and a burst instruction-fetch port.
// After every reset the whole array is cleared to zero before commands are accepted.
module prog_data_mem #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned FETCH_LEN = 2,
   parameter bit          RDW_MODE  = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              ready,
   input  logic              write_en,
   input  logic              read_en,
   input  logic [ADDR_W-1:0] add,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              fetch_start,
   input  logic [ADDR_W-1:0] fetch_add,
   output logic              fetch_busy,
   output logic [DATA_W-1:0] ir_out,
   output logic              ir_valid,
   output logic              ir_last
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [3:0]  LAST  = 4'(FETCH_LEN - 1);

   typedef enum logic [1:0] {CLEAR, IDLE, FETCH} state_t;

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [ADDR_W-1:0]   clr_cnt;
   logic [ADDR_W-1:0]   ptr;
   logic [3:0]          cnt;
   logic [DATA_W-1:0]   data_rd;
   logic [DATA_W-1:0]   fetch_rd;

   assign ready      = (state != CLEAR);
   assign fetch_busy = (state == FETCH);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= CLEAR;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (clr_cnt == '1) state_nxt = IDLE;
         IDLE:    if (fetch_start) state_nxt = FETCH;
         FETCH:   if (cnt == LAST) state_nxt = IDLE;
         default: state_nxt = CLEAR;
      endcase
   end

   // Both read paths see the write of the same cycle as new or old data depending on RDW_MODE.
   always_comb begin
      data_rd  = mem[add];
      fetch_rd = mem[ptr];
      if (RDW_MODE && write_en) begin
         data_rd = data_in;
         if (ptr == add) fetch_rd = data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == CLEAR) mem[clr_cnt] <= '0;
         else if (write_en)  mem[add]     <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clr_cnt    <= '0;
         ptr        <= '0;
         cnt        <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         ir_out     <= '0;
         ir_valid   <= 1'b0;
         ir_last    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         ir_valid   <= 1'b0;
         ir_last    <= 1'b0;
         case (state)
            CLEAR: clr_cnt <= clr_cnt + ADDR_W'(1);
            IDLE: begin
               if (fetch_start) begin
                  ptr <= fetch_add;
                  cnt <= '0;
               end
            end
            FETCH: begin
               ir_out   <= fetch_rd;
               ir_valid <= 1'b1;
               ir_last  <= (cnt == LAST);
               ptr      <= ptr + ADDR_W'(1);
               cnt      <= cnt + 4'd1;
            end
            default: ;
         endcase
         if (state != CLEAR && read_en) begin
            data_out   <= data_rd;
            data_valid <= 1'b1;
         end
      end
   end

endmodule
